wino_tile_gather_22_32: RTL and testbench

- Serial-to-parallel tile assembler that sits directly upstream of the Winograd B^T·d·B input transform for F(2x2,3x2).
- Accepts one activation element per cycle on a valid/ready stream and groups 12 elements into a 4x3 input tile.
- Presents the whole tile in parallel on dout0..dout11, which connect one-to-one to the transform's din0..din11.
- Uses two tile banks (ping-pong), so one tile can fill while the previous tile waits for the transform stage.

---
 rtl/wino_tile_gather_22_32_pkg.sv | 14 +
 rtl/wino_tile_bank.sv | 39 +++
 rtl/wino_tile_gather_22_32.sv | 139 +++++++++++++
 tb/tb_wino_tile_gather_22_32.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wino_tile_gather_22_32_pkg.sv
// Shared tile geometry for the Winograd F(2x2,3x2) input tile gatherer.
package wino_tile_gather_22_32_pkg;

    localparam int unsigned TILE_ROWS  = 4;
    localparam int unsigned TILE_COLS  = 3;
    localparam int unsigned TILE_ELEMS = TILE_ROWS * TILE_COLS;
    localparam int unsigned BEAT_W     = 4;

    typedef logic [BEAT_W-1:0] beat_idx_t;

    // Index of the final raster beat of a tile
    localparam beat_idx_t LAST_BEAT = beat_idx_t'(TILE_ELEMS - 1);

endpackage

// File: rtl/wino_tile_bank.sv
// One tile bank: 12 element registers, written one beat at a time, read in parallel.
module wino_tile_bank
    import wino_tile_gather_22_32_pkg::*;
#(
    parameter int unsigned data_width = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  beat_idx_t             i_widx,
    input  logic [data_width-1:0] i_wdata,
    output logic [data_width-1:0] o_q [TILE_ELEMS]
);

    logic [data_width-1:0] r_mem [TILE_ELEMS];

    // Element storage; cleared on reset so the outputs start at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(TILE_ELEMS); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(TILE_ELEMS); i++) begin
                if (i_we && (i_widx == beat_idx_t'(i))) begin
                    r_mem[i] <= i_wdata;
                end
            end
        end
    end

    // Parallel readout of all entries
    always_comb begin
        for (int i = 0; i < int'(TILE_ELEMS); i++) begin
            o_q[i] = r_mem[i];
        end
    end

endmodule

// File: rtl/wino_tile_gather_22_32.sv
// Serial-to-parallel 4x3 tile assembler with ping-pong banks feeding the
// Winograd input transform.
module wino_tile_gather_22_32
    import wino_tile_gather_22_32_pkg::*;
#(
    parameter int unsigned data_width = 20,
    parameter int unsigned cnt_width  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [data_width-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [data_width-1:0] dout0,
    output logic [data_width-1:0] dout1,
    output logic [data_width-1:0] dout2,
    output logic [data_width-1:0] dout3,
    output logic [data_width-1:0] dout4,
    output logic [data_width-1:0] dout5,
    output logic [data_width-1:0] dout6,
    output logic [data_width-1:0] dout7,
    output logic [data_width-1:0] dout8,
    output logic [data_width-1:0] dout9,
    output logic [data_width-1:0] dout10,
    output logic [data_width-1:0] dout11,
    output logic [cnt_width-1:0]  tile_cnt,
    output logic                  err_align
);

    logic [1:0]           r_full;
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    beat_idx_t            r_beat;
    logic [cnt_width-1:0] r_tile_cnt;
    logic                 r_err;

    logic                  w_acc;
    logic                  w_beat_last;
    logic                  w_hand;
    logic [1:0]            w_full_d;
    logic [data_width-1:0] w_q0   [TILE_ELEMS];
    logic [data_width-1:0] w_q1   [TILE_ELEMS];
    logic [data_width-1:0] w_dout [TILE_ELEMS];

    assign s_ready     = rst_n & ~r_full[r_wr_ptr];
    assign w_acc       = s_valid & s_ready;
    assign w_beat_last = (r_beat == LAST_BEAT);
    assign m_valid     = r_full[r_rd_ptr];
    assign w_hand      = m_valid & m_ready;
    assign tile_cnt    = r_tile_cnt;
    assign err_align   = r_err;

    wino_tile_bank #(
        .data_width (data_width)
    ) u_bank0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_acc && !r_wr_ptr),
        .i_widx  (r_beat),
        .i_wdata (s_data),
        .o_q     (w_q0)
    );

    wino_tile_bank #(
        .data_width (data_width)
    ) u_bank1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_acc && r_wr_ptr),
        .i_widx  (r_beat),
        .i_wdata (s_data),
        .o_q     (w_q1)
    );

    // Full flags: a completed write and a handoff of the other bank may coincide
    always_comb begin
        w_full_d = r_full;
        if (w_hand) begin
            w_full_d[r_rd_ptr] = 1'b0;
        end
        if (w_acc && w_beat_last) begin
            w_full_d[r_wr_ptr] = 1'b1;
        end
    end

    // Pointers, beat index, tile counter and sticky alignment error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full     <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_beat     <= '0;
            r_tile_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_full <= w_full_d;
            if (w_acc) begin
                if (w_beat_last) begin
                    r_beat   <= '0;
                    r_wr_ptr <= ~r_wr_ptr;
                end else if (s_last) begin
                    // Early s_last: drop the partial tile and restart at beat 0
                    r_beat <= '0;
                    r_err  <= 1'b1;
                end else begin
                    r_beat <= r_beat + beat_idx_t'(1);
                end
            end
            if (w_hand) begin
                r_rd_ptr   <= ~r_rd_ptr;
                r_tile_cnt <= r_tile_cnt + cnt_width'(1);
            end
        end
    end

    // Output mux selects the read bank
    always_comb begin
        for (int i = 0; i < int'(TILE_ELEMS); i++) begin
            w_dout[i] = r_rd_ptr ? w_q1[i] : w_q0[i];
        end
    end

    assign dout0  = w_dout[0];
    assign dout1  = w_dout[1];
    assign dout2  = w_dout[2];
    assign dout3  = w_dout[3];
    assign dout4  = w_dout[4];
    assign dout5  = w_dout[5];
    assign dout6  = w_dout[6];
    assign dout7  = w_dout[7];
    assign dout8  = w_dout[8];
    assign dout9  = w_dout[9];
    assign dout10 = w_dout[10];
    assign dout11 = w_dout[11];

endmodule

// File: tb/tb_wino_tile_gather_22_32.sv
// Directed bench for the tile gatherer, including a Winograd transform golden check.
module tb_wino_tile_gather_22_32;

    localparam int DW = 20;
    localparam int CW = 16;

    typedef logic [DW-1:0] dtile_t [12];
    typedef int            itile_t [12];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] dout [12];
    logic [CW-1:0] tile_cnt;
    logic          err_align;

    int total = 0;
    int bad   = 0;
    logic [CW-1:0] exp_cnt = '0;

    always #5 clk = ~clk;

    wino_tile_gather_22_32 #(
        .data_width (DW),
        .cnt_width  (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .dout0     (dout[0]),
        .dout1     (dout[1]),
        .dout2     (dout[2]),
        .dout3     (dout[3]),
        .dout4     (dout[4]),
        .dout5     (dout[5]),
        .dout6     (dout[6]),
        .dout7     (dout[7]),
        .dout8     (dout[8]),
        .dout9     (dout[9]),
        .dout10    (dout[10]),
        .dout11    (dout[11]),
        .tile_cnt  (tile_cnt),
        .err_align (err_align)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat, wait (bounded) for s_ready, then clock it in; s_valid stays high
    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        n = 0;
        while (!s_ready && n < 50) begin
            step();
            n++;
        end
        chk("sready_wait", {31'd0, s_ready}, 32'd1);
        step();
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // B^T d B for a 4x3 raster tile: F(2,3) row transform, 3-tap column transform
    function automatic itile_t xform(input dtile_t d);
        itile_t t;
        itile_t y;
        for (int c = 0; c < 3; c++) begin
            t[0*3+c] = int'(d[0*3+c]) - int'(d[2*3+c]);
            t[1*3+c] = int'(d[1*3+c]) + int'(d[2*3+c]);
            t[2*3+c] = int'(d[2*3+c]) - int'(d[1*3+c]);
            t[3*3+c] = int'(d[1*3+c]) - int'(d[3*3+c]);
        end
        for (int r = 0; r < 4; r++) begin
            y[r*3+0] = t[r*3+0] - t[r*3+1];
            y[r*3+1] = t[r*3+1];
            y[r*3+2] = t[r*3+2] - t[r*3+1];
        end
        return y;
    endfunction

    initial begin
        logic [DW-1:0] cap [$];
        logic          rdy_ok;
        dtile_t        gold_in;
        dtile_t        obs_in;
        itile_t        y_obs;
        itile_t        y_exp;

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_tile_cnt", {16'd0, tile_cnt}, 32'd0);
        chk("rst_err", {31'd0, err_align}, 32'd0);
        chk("rst_dout0", {12'd0, dout[0]}, 32'd0);
        chk("rst_dout11", {12'd0, dout[11]}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_s_ready", {31'd0, s_ready}, 32'd1);

        // Single tile 1..12
        m_ready = 1'b1;
        for (int i = 0; i < 11; i++) send_beat(DW'(i + 1), 1'b0);
        chk("t1_no_early_valid", {31'd0, m_valid}, 32'd0);
        send_beat(DW'(12), 1'b1);
        idle();
        chk("t1_m_valid", {31'd0, m_valid}, 32'd1);
        for (int i = 0; i < 12; i++) chk($sformatf("t1_dout%0d", i), {12'd0, dout[i]}, i + 1);
        step();
        exp_cnt++;
        chk("t1_tile_cnt", {16'd0, tile_cnt}, {16'd0, exp_cnt});
        chk("t1_valid_drop", {31'd0, m_valid}, 32'd0);
        chk("t1_err", {31'd0, err_align}, 32'd0);

        // 36 beats back to back
        rdy_ok = 1'b1;
        for (int i = 0; i < 36; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(i + 1);
            s_last  = (i % 12 == 11);
            if (!s_ready) rdy_ok = 1'b0;
            step();
            if (m_valid) cap.push_back(dout[0]);
        end
        idle();
        step();
        exp_cnt += 3;
        chk("t2_s_ready_steady", {31'd0, rdy_ok}, 32'd1);
        chk("t2_tiles", cap.size(), 32'd3);
        if (cap.size() == 3) begin
            chk("t2_dout0_a", {12'd0, cap[0]}, 32'd1);
            chk("t2_dout0_b", {12'd0, cap[1]}, 32'd13);
            chk("t2_dout0_c", {12'd0, cap[2]}, 32'd25);
        end
        chk("t2_tile_cnt", {16'd0, tile_cnt}, {16'd0, exp_cnt});

        // Backpressure: both banks fill, input stalls
        m_ready = 1'b0;
        for (int i = 0; i < 24; i++) send_beat(DW'(i + 1), (i % 12 == 11));
        s_data = DW'(25);
        s_last = 1'b0;
        chk("t3_s_ready_full", {31'd0, s_ready}, 32'd0);
        chk("t3_m_valid", {31'd0, m_valid}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t3_hold_ready", {31'd0, s_ready}, 32'd0);
            chk("t3_hold_dout0", {12'd0, dout[0]}, 32'd1);
        end
        m_ready = 1'b1;
        #1;
        chk("t3_no_comb_ready", {31'd0, s_ready}, 32'd0);
        step();
        m_ready = 1'b0;
        exp_cnt++;
        chk("t3_ready_back", {31'd0, s_ready}, 32'd1);
        chk("t3_next_dout0", {12'd0, dout[0]}, 32'd13);
        chk("t3_cnt_a", {16'd0, tile_cnt}, {16'd0, exp_cnt});
        for (int i = 24; i < 36; i++) send_beat(DW'(i + 1), (i == 35));
        idle();
        chk("t3_still_13", {12'd0, dout[0]}, 32'd13);
        m_ready = 1'b1;
        step();
        chk("t3_third_dout0", {12'd0, dout[0]}, 32'd25);
        chk("t3_third_dout11", {12'd0, dout[11]}, 32'd36);
        step();
        exp_cnt += 2;
        chk("t3_cnt_b", {16'd0, tile_cnt}, {16'd0, exp_cnt});
        chk("t3_drained", {31'd0, m_valid}, 32'd0);

        // Early s_last on beat 5
        for (int i = 0; i < 5; i++) send_beat(DW'(50 + i), (i == 4));
        idle();
        step();
        chk("t4_err", {31'd0, err_align}, 32'd1);
        chk("t4_no_partial", {31'd0, m_valid}, 32'd0);
        for (int i = 0; i < 12; i++) send_beat(DW'(100 + i), (i == 11));
        idle();
        chk("t4_m_valid", {31'd0, m_valid}, 32'd1);
        chk("t4_dout0", {12'd0, dout[0]}, 32'd100);
        chk("t4_dout11", {12'd0, dout[11]}, 32'd111);
        step();
        exp_cnt++;
        chk("t4_err_sticky", {31'd0, err_align}, 32'd1);
        chk("t4_cnt", {16'd0, tile_cnt}, {16'd0, exp_cnt});

        // Reset mid-tile
        for (int i = 0; i < 7; i++) send_beat(DW'(300 + i), 1'b0);
        idle();
        rst_n = 1'b0;
        step();
        chk("t5_rst_ready", {31'd0, s_ready}, 32'd0);
        rst_n = 1'b1;
        exp_cnt = '0;
        step();
        chk("t5_m_valid", {31'd0, m_valid}, 32'd0);
        chk("t5_cnt", {16'd0, tile_cnt}, 32'd0);
        chk("t5_err_clr", {31'd0, err_align}, 32'd0);
        step();
        chk("t5_no_pulse", {31'd0, m_valid}, 32'd0);
        for (int i = 0; i < 12; i++) send_beat(DW'(200 + i), (i == 11));
        idle();
        chk("t5_valid", {31'd0, m_valid}, 32'd1);
        chk("t5_dout0", {12'd0, dout[0]}, 32'd200);
        chk("t5_dout11", {12'd0, dout[11]}, 32'd211);
        step();
        exp_cnt++;
        chk("t5_cnt_after", {16'd0, tile_cnt}, {16'd0, exp_cnt});

        // Random tiles through the transform golden model
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 12; i++) gold_in[i] = DW'($urandom);
            for (int i = 0; i < 12; i++) send_beat(gold_in[i], (i == 11));
            idle();
            chk("t6_valid", {31'd0, m_valid}, 32'd1);
            for (int i = 0; i < 12; i++) obs_in[i] = dout[i];
            y_obs = xform(obs_in);
            y_exp = xform(gold_in);
            for (int i = 0; i < 12; i++) chk($sformatf("t6_tile%0d_y%0d", t, i), y_obs[i], y_exp[i]);
            step();
            exp_cnt++;
        end
        chk("t6_cnt", {16'd0, tile_cnt}, {16'd0, exp_cnt});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
